// File: rtl/johnson_cnt_gen_if.sv
// ---------------------------------------------------------------------------
// johnson_cnt_gen_if
// Bundles the control inputs and status outputs of the Johnson counter.
//   en        count enable, one step per cycle while high
//   dir       0 = forward, 1 = reverse
//   load      parallel load strobe
//   load_val  value taken on load
//   cnt       registered counter state
//   phase     registered index of cnt in the Johnson sequence
//   wrap      one-cycle pulse when the sequence boundary is crossed
//   load_err  one-cycle pulse on an illegal load value (self-correct builds)
// Modports: master drives the controls, slave is the counter itself.
// ---------------------------------------------------------------------------
interface johnson_cnt_gen_if #(
  parameter int WIDTH = 4
);
  localparam int PW = $clog2(2 * WIDTH);

  logic             en;
  logic             dir;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] cnt;
  logic [PW-1:0]    phase;
  logic             wrap;
  logic             load_err;

  modport master (
    output en, dir, load, load_val,
    input  cnt, phase, wrap, load_err
  );

  modport slave (
    input  en, dir, load, load_val,
    output cnt, phase, wrap, load_err
  );
endinterface

// File: rtl/johnson_cnt_gen.sv
// ---------------------------------------------------------------------------
// johnson_cnt_gen
// Parametrised bidirectional Johnson (twisted-ring) counter used as a
// glitch-free phase/sequence generator.
// Ports:
//   clk    system clock, rising edge
//   reset  synchronous, active-high; overrides load and enable
//   bus    johnson_cnt_gen_if.slave (en, dir, load, load_val in;
//          cnt, phase, wrap, load_err out, all registered)
// Configuration macro: SELF_CORRECT_EN
//   defined   - illegal load values are replaced by 0 and flagged on
//               load_err; an illegal cnt is forced to 0 on the next step.
//   undefined - load_val is taken unconditionally, load_err stays 0 and an
//               illegal cnt keeps shifting (phase reads 0 meanwhile).
// ---------------------------------------------------------------------------
module johnson_cnt_gen #(
  parameter int WIDTH = 4
) (
  input  logic               clk,
  input  logic               reset,
  johnson_cnt_gen_if.slave   bus
);
  localparam int PW = $clog2(2 * WIDTH);
  localparam logic [PW-1:0] LAST_PHASE = PW'(2 * WIDTH - 1);

  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [PW-1:0]    phase_q, phase_d;
  logic             wrap_q, wrap_d;
  logic             load_err_q, load_err_d;
  logic [WIDTH-1:0] step_s;

  // Pattern with k ones in the LSBs (k = 0..WIDTH).
  function automatic logic [WIDTH-1:0] lsb_ones(input int k);
    logic [WIDTH-1:0] all_ones;
    all_ones = {WIDTH{1'b1}};
    return all_ones >> (WIDTH - k);
  endfunction

  // True when v is one of the 2*WIDTH states of the Johnson sequence.
  function automatic logic is_legal(input logic [WIDTH-1:0] v);
    logic ok;
    ok = 1'b0;
    for (int k = 0; k <= WIDTH; k++) begin
      if (v == lsb_ones(k)) ok = 1'b1;
      else                  ok = ok;
    end
    for (int j = 1; j < WIDTH; j++) begin
      if (v == ~lsb_ones(j)) ok = 1'b1;
      else                   ok = ok;
    end
    return ok;
  endfunction

  // Phase index of v; illegal patterns decode to 0.
  function automatic logic [PW-1:0] decode(input logic [WIDTH-1:0] v);
    logic [PW-1:0] p;
    p = {PW{1'b0}};
    for (int k = 0; k <= WIDTH; k++) begin
      if (v == lsb_ones(k)) p = PW'(k);
      else                  p = p;
    end
    // Ones in the MSBs with j zeros below them follow the all-ones state.
    for (int j = 1; j < WIDTH; j++) begin
      if (v == ~lsb_ones(j)) p = PW'(WIDTH + j);
      else                   p = p;
    end
    return p;
  endfunction

  // Single shift in the currently requested direction.
  always_comb begin
    step_s = cnt_q;
    if (bus.dir) step_s = {~cnt_q[0], cnt_q[WIDTH-1:1]};
    else         step_s = {cnt_q[WIDTH-2:0], ~cnt_q[WIDTH-1]};
  end

  // Next-state selection: load beats enable; idle holds and clears pulses.
  always_comb begin
    cnt_d      = cnt_q;
    phase_d    = phase_q;
    wrap_d     = 1'b0;
    load_err_d = 1'b0;
    if (bus.load) begin
`ifdef SELF_CORRECT_EN
      if (is_legal(bus.load_val)) begin
        cnt_d = bus.load_val;
      end else begin
        cnt_d      = {WIDTH{1'b0}};
        load_err_d = 1'b1;
      end
`else
      cnt_d = bus.load_val;
`endif
      phase_d = decode(cnt_d);
    end else if (bus.en) begin
`ifdef SELF_CORRECT_EN
      if (is_legal(cnt_q)) cnt_d = step_s;
      else                 cnt_d = {WIDTH{1'b0}};
`else
      cnt_d = step_s;
`endif
      phase_d = decode(cnt_d);
      // Only a legal state can cross the 2W-1 <-> 0 boundary.
      if (is_legal(cnt_q)) begin
        if (bus.dir) wrap_d = (phase_q == {PW{1'b0}});
        else         wrap_d = (phase_q == LAST_PHASE);
      end else begin
        wrap_d = 1'b0;
      end
    end else begin
      cnt_d   = cnt_q;
      phase_d = phase_q;
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q      <= {WIDTH{1'b0}};
      phase_q    <= {PW{1'b0}};
      wrap_q     <= 1'b0;
      load_err_q <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      phase_q    <= phase_d;
      wrap_q     <= wrap_d;
      load_err_q <= load_err_d;
    end
  end

  assign bus.cnt      = cnt_q;
  assign bus.phase    = phase_q;
  assign bus.wrap     = wrap_q;
  assign bus.load_err = load_err_q;
endmodule

// File: tb/tb_johnson_cnt_gen.sv
// ---------------------------------------------------------------------------
// tb_johnson_cnt_gen
// Table-driven check of a WIDTH=4 counter plus a free-running WIDTH=7 run.
// ---------------------------------------------------------------------------
module tb_johnson_cnt_gen;
  logic clk = 1'b0;
  logic reset4;
  logic reset7;

  always #5 clk = ~clk;

  johnson_cnt_gen_if #(.WIDTH(4)) bus4 ();
  johnson_cnt_gen_if #(.WIDTH(7)) bus7 ();

  johnson_cnt_gen #(.WIDTH(4)) dut4 (.clk(clk), .reset(reset4), .bus(bus4));
  johnson_cnt_gen #(.WIDTH(7)) dut7 (.clk(clk), .reset(reset7), .bus(bus7));

  typedef struct {
    logic       rst;
    logic       en;
    logic       dir;
    logic       load;
    logic [3:0] lv;
    logic [3:0] ecnt;
    logic [2:0] eph;
    logic       ewrap;
    logic       eerr;
  } vec_t;

  vec_t vecs[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  function automatic void add(input logic rst, input logic en, input logic dir,
                              input logic load, input logic [3:0] lv,
                              input logic [3:0] ecnt, input logic [2:0] eph,
                              input logic ewrap, input logic eerr);
    vec_t v;
    v.rst = rst; v.en = en; v.dir = dir; v.load = load; v.lv = lv;
    v.ecnt = ecnt; v.eph = eph; v.ewrap = ewrap; v.eerr = eerr;
    vecs.push_back(v);
  endfunction

  task automatic chk(input string name, input int idx,
                     input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s[%0d]: got %0h expected %0h", name, idx, act, exp);
    end
  endtask

  // Expected cnt for a WIDTH=7 phase, built from the legal-state definition.
  function automatic logic [6:0] w7_state(input int p);
    logic [6:0] ones;
    ones = 7'h7F;
    if (p <= 7) return ones >> (7 - p);
    else        return ones << (p - 7);
  endfunction

  initial begin
    int prev_phase;
    int wraps;

    // reset for three cycles
    add(1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 4'b0000, 3'd0, 1'b0, 1'b0);
    add(1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 4'b0000, 3'd0, 1'b0, 1'b0);
    add(1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 4'b0000, 3'd0, 1'b0, 1'b0);
    // T1 forward through one full sequence
    add(1'b0, 1'b1, 1'b0, 1'b0, 4'h0, 4'b0001, 3'd1, 1'b0, 1'b0);
    add(1'b0, 1'b1, 1'b0, 1'b0, 4'h0, 4'b0011, 3'd2, 1'b0, 1'b0);
    add(1'b0, 1'b1, 1'b0, 1'b0, 4'h0, 4'b0111, 3'd3, 1'b0, 1'b0);
    add(1'b0, 1'b1, 1'b0, 1'b0, 4'h0, 4'b1111, 3'd4, 1'b0, 1'b0);
    add(1'b0, 1'b1, 1'b0, 1'b0, 4'h0, 4'b1110, 3'd5, 1'b0, 1'b0);
    add(1'b0, 1'b1, 1'b0, 1'b0, 4'h0, 4'b1100, 3'd6, 1'b0, 1'b0);
    add(1'b0, 1'b1, 1'b0, 1'b0, 4'h0, 4'b1000, 3'd7, 1'b0, 1'b0);
    add(1'b0, 1'b1, 1'b0, 1'b0, 4'h0, 4'b0000, 3'd0, 1'b1, 1'b0);
    add(1'b0, 1'b1, 1'b0, 1'b0, 4'h0, 4'b0001, 3'd1, 1'b0, 1'b0);
    add(1'b0, 1'b1, 1'b0, 1'b0, 4'h0, 4'b0011, 3'd2, 1'b0, 1'b0);
    add(1'b0, 1'b1, 1'b0, 1'b0, 4'h0, 4'b0111, 3'd3, 1'b0, 1'b0);
    // hold
    add(1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 4'b0111, 3'd3, 1'b0, 1'b0);
    // T2 reverse across phase 0
    add(1'b0, 1'b1, 1'b1, 1'b0, 4'h0, 4'b0011, 3'd2, 1'b0, 1'b0);
    add(1'b0, 1'b1, 1'b1, 1'b0, 4'h0, 4'b0001, 3'd1, 1'b0, 1'b0);
    add(1'b0, 1'b1, 1'b1, 1'b0, 4'h0, 4'b0000, 3'd0, 1'b0, 1'b0);
    add(1'b0, 1'b1, 1'b1, 1'b0, 4'h0, 4'b1000, 3'd7, 1'b1, 1'b0);
    add(1'b0, 1'b1, 1'b1, 1'b0, 4'h0, 4'b1100, 3'd6, 1'b0, 1'b0);
    // direction flip without bubble
    add(1'b0, 1'b1, 1'b0, 1'b0, 4'h0, 4'b1000, 3'd7, 1'b0, 1'b0);
    // T3 load beats enable
    add(1'b0, 1'b1, 1'b1, 1'b1, 4'b1100, 4'b1100, 3'd6, 1'b0, 1'b0);
    add(1'b0, 1'b1, 1'b0, 1'b0, 4'h0, 4'b1000, 3'd7, 1'b0, 1'b0);
    // load onto phase 0 from phase 7 never wraps
    add(1'b0, 1'b1, 1'b0, 1'b1, 4'b0000, 4'b0000, 3'd0, 1'b0, 1'b0);
    // load onto phase 7 from phase 0 never wraps
    add(1'b0, 1'b1, 1'b1, 1'b1, 4'b1000, 4'b1000, 3'd7, 1'b0, 1'b0);
    // T4 illegal load, then hold, then a forward step
`ifdef SELF_CORRECT_EN
    add(1'b0, 1'b0, 1'b0, 1'b1, 4'b0101, 4'b0000, 3'd0, 1'b0, 1'b1);
    add(1'b0, 1'b0, 1'b0, 1'b0, 4'h0,    4'b0000, 3'd0, 1'b0, 1'b0);
    add(1'b0, 1'b1, 1'b0, 1'b0, 4'h0,    4'b0001, 3'd1, 1'b0, 1'b0);
`else
    add(1'b0, 1'b0, 1'b0, 1'b1, 4'b0101, 4'b0101, 3'd0, 1'b0, 1'b0);
    add(1'b0, 1'b0, 1'b0, 1'b0, 4'h0,    4'b0101, 3'd0, 1'b0, 1'b0);
    add(1'b0, 1'b1, 1'b0, 1'b0, 4'h0,    4'b1011, 3'd0, 1'b0, 1'b0);
`endif
    // T5 go to phase 5, reset with en and load high, then resume
    add(1'b0, 1'b0, 1'b0, 1'b1, 4'b1110, 4'b1110, 3'd5, 1'b0, 1'b0);
    add(1'b1, 1'b1, 1'b0, 1'b1, 4'b1111, 4'b0000, 3'd0, 1'b0, 1'b0);
    add(1'b0, 1'b1, 1'b0, 1'b0, 4'h0,    4'b0001, 3'd1, 1'b0, 1'b0);

    reset7        = 1'b1;
    bus7.en       = 1'b0;
    bus7.dir      = 1'b0;
    bus7.load     = 1'b0;
    bus7.load_val = 7'h00;

    for (int i = 0; i < vecs.size(); i++) begin
      reset4        = vecs[i].rst;
      bus4.en       = vecs[i].en;
      bus4.dir      = vecs[i].dir;
      bus4.load     = vecs[i].load;
      bus4.load_val = vecs[i].lv;
      @(posedge clk);
      #1;
      chk("cnt",      i, 32'(bus4.cnt),      32'(vecs[i].ecnt));
      chk("phase",    i, 32'(bus4.phase),    32'(vecs[i].eph));
      chk("wrap",     i, 32'(bus4.wrap),     32'(vecs[i].ewrap));
      chk("load_err", i, 32'(bus4.load_err), 32'(vecs[i].eerr));
    end
    reset4   = 1'b0;
    bus4.en  = 1'b0;
    bus4.load = 1'b0;

    // T6 WIDTH=7 free-run forward for 28 steps
    @(posedge clk);
    #1;
    chk("w7_reset_cnt", 0, 32'(bus7.cnt), 32'd0);
    chk("w7_reset_phase", 0, 32'(bus7.phase), 32'd0);
    reset7     = 1'b0;
    bus7.en    = 1'b1;
    prev_phase = 0;
    wraps      = 0;
    for (int s = 1; s <= 28; s++) begin
      @(posedge clk);
      #1;
      chk("w7_phase", s, 32'(bus7.phase), 32'((prev_phase + 1) % 14));
      chk("w7_cnt",   s, 32'(bus7.cnt),   32'(w7_state((prev_phase + 1) % 14)));
      chk("w7_wrap",  s, 32'(bus7.wrap),  32'((s % 14) == 0));
      if (bus7.wrap) wraps++;
      prev_phase = int'(bus7.phase);
    end
    bus7.en = 1'b0;
    chk("w7_wrap_count", 0, 32'(wraps), 32'd2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
